collision_scanner: RTL and testbench

//  Per-frame collision checker: player car box against NUM_OBJ object boxes (enemy cars, obstacles).
//  A start pulse, issued once per frame at vblank, triggers a scan of one object per clock through a single shared comparator.

---
 rtl/road_pkg.sv | 16 +
 rtl/box_overlap.sv | 38 +++
 rtl/collision_scanner.sv | 130 +++++++++++++
 tb/tb_collision_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_pkg.sv
// Shared road-scene constants and the collision scanner state encoding.
package road_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 10;
  localparam int CAR_WIDTH  = 16;
  localparam int CAR_HEIGHT = 32;
  localparam int MAX_OBJ    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/box_overlap.sv
// Combinational strict-overlap test between box A (at ax,ay) and box B (at bx,by).
module box_overlap #(
  parameter int X_W = 8,
  parameter int Y_W = 10,
  parameter int A_W = 16,
  parameter int A_H = 32,
  parameter int B_W = 16,
  parameter int B_H = 32
) (
  input  logic [X_W-1:0] ax,
  input  logic [Y_W-1:0] ay,
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  output logic           hit
);

  localparam logic [X_W:0] A_W_C = (X_W+1)'(A_W);
  localparam logic [X_W:0] B_W_C = (X_W+1)'(B_W);
  localparam logic [Y_W:0] A_H_C = (Y_W+1)'(A_H);
  localparam logic [Y_W:0] B_H_C = (Y_W+1)'(B_H);

  // One extra bit keeps the far edges from wrapping past the screen bound.
  logic [X_W:0] ax_s, bx_s, ax_end_s, bx_end_s;
  logic [Y_W:0] ay_s, by_s, ay_end_s, by_end_s;

  assign ax_s     = {1'b0, ax};
  assign bx_s     = {1'b0, bx};
  assign ay_s     = {1'b0, ay};
  assign by_s     = {1'b0, by};
  assign ax_end_s = ax_s + A_W_C;
  assign bx_end_s = bx_s + B_W_C;
  assign ay_end_s = ay_s + A_H_C;
  assign by_end_s = by_s + B_H_C;

  assign hit = (ax_s < bx_end_s) && (bx_s < ax_end_s) &&
               (ay_s < by_end_s) && (by_s < ay_end_s);

endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision scan: one object slot per clock through a shared comparator,
// results latched and held until the next scan finishes.
module collision_scanner
  import road_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int X_W     = road_pkg::X_W,
  parameter int Y_W     = road_pkg::Y_W,
  parameter int PL_W    = road_pkg::CAR_WIDTH,
  parameter int PL_H    = road_pkg::CAR_HEIGHT,
  parameter int OBJ_W   = road_pkg::CAR_WIDTH,
  parameter int OBJ_H   = road_pkg::CAR_HEIGHT,
  parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [X_W-1:0]         player_x,
  input  logic [Y_W-1:0]         player_y,
  input  logic [NUM_OBJ*X_W-1:0] obj_x,
  input  logic [NUM_OBJ*Y_W-1:0] obj_y,
  input  logic [NUM_OBJ-1:0]     obj_valid,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_OBJ-1:0]     hit_mask,
  output logic                   hit_any,
  output logic [IDX_W-1:0]       first_hit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  scan_state_e          state_r;
  logic [IDX_W-1:0]     idx_r;
  logic [NUM_OBJ-1:0]   work_r;
  logic [NUM_OBJ-1:0]   valid_r;
  logic [X_W-1:0]       player_x_r;
  logic [Y_W-1:0]       player_y_r;
  logic [X_W-1:0]       obj_x_r [NUM_OBJ];
  logic [Y_W-1:0]       obj_y_r [NUM_OBJ];
  logic [X_W-1:0]       cur_x_s;
  logic [Y_W-1:0]       cur_y_s;
  logic                 overlap_s;

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_OBJ-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign cur_x_s = obj_x_r[idx_r];
  assign cur_y_s = obj_y_r[idx_r];

  box_overlap #(
    .X_W(X_W), .Y_W(Y_W),
    .A_W(PL_W), .A_H(PL_H),
    .B_W(OBJ_W), .B_H(OBJ_H)
  ) u_overlap (
    .ax (player_x_r),
    .ay (player_y_r),
    .bx (cur_x_s),
    .by (cur_y_s),
    .hit(overlap_s)
  );

  // Scan FSM: snapshot, step through slots, publish results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      work_r        <= '0;
      valid_r       <= '0;
      player_x_r    <= '0;
      player_y_r    <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_x_r[i] <= '0;
        obj_y_r[i] <= '0;
      end
      busy          <= 1'b0;
      done          <= 1'b0;
      hit_mask      <= '0;
      hit_any       <= 1'b0;
      first_hit_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            player_x_r <= player_x;
            player_y_r <= player_y;
            valid_r    <= obj_valid;
            for (int i = 0; i < NUM_OBJ; i++) begin
              obj_x_r[i] <= obj_x[i*X_W +: X_W];
              obj_y_r[i] <= obj_y[i*Y_W +: Y_W];
            end
            work_r  <= '0;
            idx_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          work_r[idx_r] <= valid_r[idx_r] & overlap_s;
          if (idx_r == LAST_IDX) begin
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          hit_mask      <= work_r;
          hit_any       <= |work_r;
          first_hit_idx <= first_set(work_r);
          done          <= 1'b1;
          busy          <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed self-checking bench for collision_scanner (NUM_OBJ=8, 16x32 boxes).
module tb_collision_scanner;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  player_x;
  logic [9:0]  player_y;
  logic [63:0] obj_x;
  logic [79:0] obj_y;
  logic [7:0]  obj_valid;
  logic        busy;
  logic        done;
  logic [7:0]  hit_mask;
  logic        hit_any;
  logic [2:0]  first_hit_idx;

  int checks;
  int errors;

  collision_scanner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .player_x     (player_x),
    .player_y     (player_y),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_valid    (obj_valid),
    .busy         (busy),
    .done         (done),
    .hit_mask     (hit_mask),
    .hit_any      (hit_any),
    .first_hit_idx(first_hit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_objs();
    obj_x     = '0;
    obj_y     = '0;
    obj_valid = '0;
  endtask

  task automatic set_obj(input int i, input logic [7:0] x, input logic [9:0] y, input logic v);
    obj_x[i*8 +: 8]  = x;
    obj_y[i*10 +: 10] = y;
    obj_valid[i]     = v;
  endtask

  // Pulse start for one edge, then watch 14 edges; lat = edge of first done (0 if none).
  task automatic run_scan(output int lat, output int ndone);
    lat   = 0;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] m, input logic a, input logic [2:0] f);
    checks++;
    if (hit_mask !== m) begin
      errors++;
      $display("FAIL %s hit_mask: got 0x%02h expected 0x%02h", name, hit_mask, m);
    end
    checks++;
    if (hit_any !== a) begin
      errors++;
      $display("FAIL %s hit_any: got %b expected %b", name, hit_any, a);
    end
    checks++;
    if (first_hit_idx !== f) begin
      errors++;
      $display("FAIL %s first_hit_idx: got %0d expected %0d", name, first_hit_idx, f);
    end
  endtask

  task automatic check_timing(input string name, input int lat, input int ndone);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 9", name, lat);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1", name, ndone);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    player_x = '0;
    player_y = '0;
    clear_objs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    check_result("reset", 8'h00, 1'b0, 3'd0);
  endtask

  task automatic test_basic_hit();
    int lat, nd;
    player_x = 8'd100; player_y = 10'd200;
    clear_objs();
    set_obj(0, 8'd110, 10'd210, 1'b1);
    set_obj(4, 8'd105, 10'd205, 1'b0);
    run_scan(lat, nd);
    check_timing("basic", lat, nd);
    check_result("basic", 8'h01, 1'b1, 3'd0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_touching_edge();
    int lat, nd;
    player_x = 8'd100; player_y = 10'd200;
    clear_objs();
    set_obj(3, 8'd116, 10'd200, 1'b1);
    set_obj(6, 8'd100, 10'd232, 1'b1);
    run_scan(lat, nd);
    check_timing("touch", lat, nd);
    check_result("touch", 8'h00, 1'b0, 3'd0);
  endtask

  task automatic test_no_wrap();
    int lat, nd;
    player_x = 8'd248; player_y = 10'd1000;
    clear_objs();
    set_obj(2, 8'd240, 10'd990, 1'b1);
    set_obj(5, 8'd0, 10'd0, 1'b1);
    run_scan(lat, nd);
    check_timing("nowrap", lat, nd);
    check_result("nowrap", 8'h04, 1'b1, 3'd2);
  endtask

  task automatic test_invalid_slot();
    int lat, nd;
    player_x = 8'd100; player_y = 10'd200;
    clear_objs();
    set_obj(1, 8'd100, 10'd200, 1'b0);
    set_obj(5, 8'd90, 10'd190, 1'b1);
    set_obj(6, 8'd0, 10'd0, 1'b1);
    run_scan(lat, nd);
    check_result("invalid", 8'h20, 1'b1, 3'd5);
  endtask

  task automatic test_multi_hit();
    int lat, nd;
    player_x = 8'd50; player_y = 10'd50;
    clear_objs();
    set_obj(0, 8'd50, 10'd82, 1'b1);
    set_obj(4, 8'd50, 10'd50, 1'b1);
    set_obj(7, 8'd40, 10'd70, 1'b1);
    run_scan(lat, nd);
    check_result("multi", 8'h90, 1'b1, 3'd4);
    repeat (5) @(posedge clk);
    #1;
    check_result("hold", 8'h90, 1'b1, 3'd4);
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    lat = 0;
    nd  = 0;
    player_x = 8'd100; player_y = 10'd200;
    clear_objs();
    set_obj(0, 8'd110, 10'd210, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (lat == 0) lat = n;
      end
      if (n == 3) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy_mid: got %b expected 1", busy); end
        start = 1'b1;
        set_obj(0, 8'd200, 10'd210, 1'b1);
        set_obj(2, 8'd100, 10'd200, 1'b1);
      end else begin
        start = 1'b0;
      end
    end
    check_timing("b2b", lat, nd);
    check_result("b2b", 8'h01, 1'b1, 3'd0);
    run_scan(lat, nd);
    check_result("b2b_next", 8'h04, 1'b1, 3'd2);
  endtask

  task automatic test_reset_mid_scan();
    int lat, nd;
    player_x = 8'd100; player_y = 10'd200;
    clear_objs();
    set_obj(0, 8'd110, 10'd210, 1'b1);
    run_scan(lat, nd);
    check_result("rst_pre", 8'h01, 1'b1, 3'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    check_result("rstmid", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL rstmid stray_done: got %0d expected 0", nd); end
    run_scan(lat, nd);
    check_timing("rst_after", lat, nd);
    check_result("rst_after", 8'h01, 1'b1, 3'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_hit();
    test_touching_edge();
    test_no_wrap();
    test_invalid_slot();
    test_multi_hit();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
